// File: rtl/pcs_10g_pkg.sv
// Shared PCS definitions: block geometry, sync header codes and the
// stream-order to block-port remap used by the RX gearbox.
package pcs_10g_pkg;

  localparam int BLK_W   = 66;
  localparam int CNT_W   = 7;
  localparam int HDR_LSB = 64;
  localparam int HDR_MSB = 65;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Stream-ordered bits (bit 0 = s0) to the block port layout:
  // [64]=s0, [65]=s1, [63:0]=s65..s2.
  function automatic logic [BLK_W-1:0] remap_block(input logic [BLK_W-1:0] sv);
    logic [BLK_W-1:0] blk;
    blk                  = '0;
    blk[HDR_MSB:HDR_LSB] = sv[1:0];
    blk[HDR_LSB-1:0]     = sv[BLK_W-1:2];
    return blk;
  endfunction

endpackage

// File: rtl/pcs_10g_rx_gearbox_if.sv
// SERDES-to-block-lock bundle around the RX gearbox.
// Handshake: rx_data_valid qualifies rx_data and rx_block_valid qualifies
// rx_block, each for exactly the cycle it is high; there is no ready, so the
// receiver of either stream must take every valid beat.
interface pcs_10g_rx_gearbox_if
  import pcs_10g_pkg::*;
#(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] rx_data;
  logic              rx_data_valid;
  logic              rx_slip;
  logic [BLK_W-1:0]  rx_block;
  logic              rx_block_valid;
  logic              rx_slip_ack;
  logic [CNT_W-1:0]  rx_fill;

  // Upstream/block-lock side: drives words and slip requests.
  modport master (
    output rx_data, rx_data_valid, rx_slip,
    input  rx_block, rx_block_valid, rx_slip_ack, rx_fill
  );

  // Gearbox side.
  modport slave (
    input  rx_data, rx_data_valid, rx_slip,
    output rx_block, rx_block_valid, rx_slip_ack, rx_fill
  );
endinterface

// File: rtl/pcs_10g_rx_gearbox.sv
// 10GBASE-R RX gearbox: packs SERDES words (bit 0 oldest) into 66-bit blocks
// and applies single-bit slips requested by block lock. No header checking.
module pcs_10g_rx_gearbox
  import pcs_10g_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  pcs_10g_rx_gearbox_if.slave rx_if
);

  localparam int BUF_W = BLK_W + WORD_W;

  if (WORD_W != 16 && WORD_W != 32) begin : g_bad_word_w
    $error("pcs_10g_rx_gearbox: WORD_W must be 16 or 32");
  end

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slip_req_q, slip_req_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             blk_vld_q, blk_vld_d;
  logic             ack_q, ack_d;

  logic [BUF_W-1:0] tmp;
  logic [CNT_W-1:0] tcnt;
  logic             slip_pend;

  // Append word, then apply a pending slip, then extract at most one block.
  // The slip is taken before extraction so it always drops the oldest bit.
  always_comb begin
    tmp        = buf_q;
    tcnt       = cnt_q;
    slip_pend  = slip_req_q | rx_if.rx_slip;
    ack_d      = 1'b0;
    blk_d      = blk_q;
    blk_vld_d  = 1'b0;
    if (rx_if.rx_data_valid) begin
      tmp  = buf_q | (BUF_W'(rx_if.rx_data) << cnt_q);
      tcnt = cnt_q + CNT_W'(WORD_W);
    end
    // With nothing buffered the request stays pending until bits arrive.
    if (slip_pend && (tcnt != '0)) begin
      tmp       = tmp >> 1;
      tcnt      = tcnt - CNT_W'(1);
      slip_pend = 1'b0;
      ack_d     = 1'b1;
    end
    slip_req_d = slip_pend;
    if (tcnt >= CNT_W'(BLK_W)) begin
      blk_d     = remap_block(tmp[BLK_W-1:0]);
      blk_vld_d = 1'b1;
      tmp       = tmp >> BLK_W;
      tcnt      = tcnt - CNT_W'(BLK_W);
    end
    // Keep everything above the fill level clear so the next OR-append is safe.
    buf_d = tmp & ~({BUF_W{1'b1}} << tcnt);
    cnt_d = tcnt;
  end

  // State and registered outputs; reset drops any partial block immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      cnt_q      <= '0;
      slip_req_q <= 1'b0;
      blk_q      <= '0;
      blk_vld_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      slip_req_q <= slip_req_d;
      blk_q      <= blk_d;
      blk_vld_q  <= blk_vld_d;
      ack_q      <= ack_d;
    end
  end

  assign rx_if.rx_block       = blk_q;
  assign rx_if.rx_block_valid = blk_vld_q;
  assign rx_if.rx_slip_ack    = ack_q;
  assign rx_if.rx_fill        = cnt_q;

endmodule
